uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Serial UART receiver, downstream of uart_tx: consumes its transmitted_bit line.
//  Recovers 8N1-style frames (start, DATA_BITS LSB-first, stop) by mid-bit sampling.
//  Presents each word with a 1-cycle valid pulse and flags bad stop bits.
//  Default parameters match uart_tx, so the two blocks loop back directly.
// PARAMETERS
//  CLK_FREQUENCY  50_000_000  system clock in Hz
//  BAUD_RATE      115_200     serial bit rate
//  DATA_BITS      7           payload bits per frame (1..16)
// PORTS
//  clk             in   1          system clock, rising edge
//  reset           in   1          synchronous, active-low reset
//  received_bit    in   1          async serial input, idles high
//  data_received   out  DATA_BITS  last good word
//  data_valid      out  1          1-cycle pulse: data_received updated
//  framing_error   out  1          1-cycle pulse: stop bit sampled low
//  busy            out  1          high whenever state != IDLE
//  parity_error    out  1          only with UART_RX_PARITY_EN
// BEHAVIOUR
//  - BAUD_DIVIDER = CLK_FREQUENCY/BAUD_RATE (integer, 434 at defaults).
//  - HALF = BAUD_DIVIDER/2 (217).
//  - received_bit passes a 2-FF synchronizer; both FFs reset to 1.
//  - Reset (reset==0 at posedge): state=IDLE, counters=0, data_received=0.
//    data_valid, framing_error, parity_error and busy all =0.
//    Applies mid-frame too: the partial word is discarded with no pulse.
//  - FSM states: IDLE, START, DATA, [PARITY], STOP.
//  - IDLE: synchronized line low -> START, baud counter cleared.
//  - START: after HALF cycles, sample the line.
//    Low -> DATA, bit index 0. High (glitch) -> IDLE, no output pulse.
//  - DATA: every BAUD_DIVIDER cycles, sample into shift register, LSB first.
//    After bit DATA_BITS-1 -> PARITY (macro on) or STOP.
//  - STOP: after BAUD_DIVIDER cycles, sample.
//    1 -> data_received <= shift reg, data_valid=1 for the next cycle.
//    0 -> framing_error=1 for one cycle, data_received unchanged.
//    Either case -> IDLE immediately, i.e. mid stop bit.
//    The next start edge is therefore detectable with no dead time.
//  - Latency: data_valid rises 1 clk after the mid-stop-bit sample edge.
//    Plus 2 synchronizer cycles relative to the line.
//  - Back-to-back frames: no idle gap needed; the stop-to-start edge is caught.
//  - Line held low (break): framing_error once, then IDLE.
//    No new frame starts until the line returns high, then low.
//  - data_valid and framing_error are never high together.
// CONFIGURATION
//  - UART_RX_PARITY_EN defined:
//    Frame carries one even-parity bit after the data bits.
//    PARITY state samples it at bit centre.
//    parity_error pulses with data_valid on mismatch; the word is still delivered.
//    Frame length is DATA_BITS+3 bits.
//  - UART_RX_PARITY_EN undefined:
//    No PARITY state and no parity_error port.
//    Frame length is DATA_BITS+2 bits, matching uart_tx.
// STRUCTURE
//  - uart_pkg holds:
//    typedef enum logic [2:0] uart_rx_state_t {IDLE, START, DATA, PARITY, STOP}.
//    function baud_divider(clk_hz, baud).
//    Shared with uart_tx.
//  - Sub-module uart_bit_sync: 2-FF synchronizer, reset value parameterised (1 here).
//  - Counter width is $clog2(BAUD_DIVIDER).
//  - Bit index width is $clog2(DATA_BITS+1).
// TESTING
//  1. Loopback uart_tx->uart_rx, 100 random 7-bit words.
//     -> Each word appears on data_received with one data_valid pulse.
//     -> framing_error never asserts.
//  2. Drive 7'h55, then 7'h2A back-to-back (stop bit immediately followed by start).
//     -> Two data_valid pulses, values 0x55 then 0x2A.
//  3. Start-bit glitch: line low for 100 clks (< HALF), then high.
//     -> Returns to IDLE, no pulses, busy drops after HALF cycles.
//  4. Frame 7'h7F with stop bit forced 0.
//     -> framing_error one cycle, data_received keeps its previous value.
//  5. Assert reset during data bit 3 of 7'h13, release, then send 7'h13.
//     -> Outputs 0 during reset, exactly one data_valid with 0x13.
//  6. UART_RX_PARITY_EN: send 7'h03 with parity=1 (wrong).
//     -> data_valid and parity_error together, data_received=0x03.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding and baud divider helper, also used by uart_tx.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_rx_state_t;

  function automatic int baud_divider(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_bit_sync.sv
// Two-flop synchronizer for a single asynchronous bit; reset value selects the idle level.
module uart_bit_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[0], d};
  end

  always_ff @(posedge clk) begin
    if (!reset) sync_q <= {2{RESET_VAL}};
    else        sync_q <= sync_d;
  end

  assign q = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/data/stop frame recovery by mid-bit sampling.
// Define UART_RX_PARITY_EN to expect an even-parity bit and expose parity_error.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQUENCY = 50_000_000,
  parameter int BAUD_RATE     = 115_200,
  parameter int DATA_BITS     = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 received_bit,
  output logic [DATA_BITS-1:0] data_received,
  output logic                 data_valid,
  output logic                 framing_error,
  output logic                 busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_error
`endif
);

  localparam int BAUD_DIVIDER = baud_divider(CLK_FREQUENCY, BAUD_RATE);
  localparam int HALF         = BAUD_DIVIDER / 2;
  localparam int CNT_W        = (BAUD_DIVIDER > 1) ? $clog2(BAUD_DIVIDER) : 1;
  localparam int IDX_W        = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(BAUD_DIVIDER - 1);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'((HALF > 0) ? HALF - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  logic rx_s;

  uart_bit_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (received_bit),
    .q     (rx_s)
  );

  uart_rx_state_t       state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 rx_prev_q, rx_prev_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 perr_q, perr_d;
`endif

  logic cnt_full;
  assign cnt_full = (cnt_q == FULL_M1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    rx_prev_d = rx_s;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif
    case (state_q)
      // Falling edge, not level: a held-low break must return high before re-arming.
      IDLE: begin
        if (rx_prev_q && !rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_full) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          idx_d          = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_full) begin
          cnt_d     = '0;
          par_bad_d = (^shift_q) ^ rx_s;
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      // Leave mid stop bit so a back-to-back start edge is not missed.
      STOP: begin
        if (cnt_full) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_d  = par_bad_q;
`endif
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      rx_prev_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      rx_prev_q <= rx_prev_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign data_received = data_q;
  assign data_valid    = valid_q;
  assign framing_error = ferr_q;
  assign busy          = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_error  = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx: a serial driver plus a frame-level expectation queue.
module tb_uart_rx;

  localparam int DW   = 7;
  localparam int CLKF = 1_600_000;
  localparam int BAUD = 100_000;
  localparam int DIV  = CLKF / BAUD;
  localparam int HALF = DIV / 2;

  typedef struct packed {
    logic          ferr;
    logic [DW-1:0] data;
    logic          perr;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          rx_line = 1'b1;
  logic [DW-1:0] data_received;
  logic          data_valid, framing_error, busy;
`ifdef UART_RX_PARITY_EN
  logic          parity_error;
`endif

  uart_rx #(.CLK_FREQUENCY(CLKF), .BAUD_RATE(BAUD), .DATA_BITS(DW)) dut (
    .clk           (clk),
    .reset         (reset),
    .received_bit  (rx_line),
    .data_received (data_received),
    .data_valid    (data_valid),
    .framing_error (framing_error),
    .busy          (busy)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_error  (parity_error)
`endif
  );

  always #5 clk = ~clk;

  int unsigned   total = 0, bad = 0;
  int unsigned   cyc = 0;
  int unsigned   last_valid_cyc = 0;
  logic          rst_seen = 1'b0;
  logic [DW-1:0] last_good = '0;
  exp_t          exp_q[$];

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= reset;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the expectation queue.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_seen) begin
      last_good = '0;
      chk("rst_valid", 32'(data_valid), 0);
      chk("rst_ferr", 32'(framing_error), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_data", 32'(data_received), 0);
`ifdef UART_RX_PARITY_EN
      chk("rst_perr", 32'(parity_error), 0);
`endif
    end else begin
      if (data_valid && framing_error) chk("valid_and_ferr", 1, 0);
      if (data_valid || framing_error) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {30'd0, data_valid, framing_error}, 0);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind", {31'd0, framing_error}, {31'd0, e.ferr});
          if (data_valid) begin
            last_valid_cyc = cyc;
            if (!e.ferr) last_good = e.data;
            chk("word", 32'(data_received), 32'(e.data));
`ifdef UART_RX_PARITY_EN
            chk("perr", 32'(parity_error), 32'(e.perr));
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      if (!data_valid && parity_error) chk("perr_stray", 1, 0);
`endif
      chk("data_hold", 32'(data_received), 32'(last_good));
    end
  end

  task automatic bit_out(input logic v);
    rx_line = v;
    repeat (DIV) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_line = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic stop_b, input logic flip_par);
    bit_out(1'b0);
    for (int i = 0; i < DW; i++) bit_out(d[i]);
`ifdef UART_RX_PARITY_EN
    bit_out((^d) ^ flip_par);
`endif
    bit_out(stop_b);
  endtask

  task automatic expect_word(input logic [DW-1:0] d, input logic perr);
    exp_t e;
    e.ferr = 1'b0; e.data = d; e.perr = perr;
    exp_q.push_back(e);
  endtask

  task automatic expect_ferr();
    exp_t e;
    e.ferr = 1'b1; e.data = '0; e.perr = 1'b0;
    exp_q.push_back(e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int unsigned start_cyc;
    logic [DW-1:0] w;
    reset   = 1'b0;
    rx_line = 1'b1;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    idle(2 * DIV);

    // Latency pin: start edge to data_valid = 2 sync + 1 + half bit + 8 (or 9) bits.
    start_cyc = cyc;
    expect_word(7'h5A, 1'b0);
    send_frame(7'h5A, 1'b1, 1'b0);
    idle(DIV);
`ifdef UART_RX_PARITY_EN
    chk("latency", last_valid_cyc - start_cyc, 155);
`else
    chk("latency", last_valid_cyc - start_cyc, 139);
`endif
    chk("last_good_5a", 32'(data_received), 32'h5A);

    // Back-to-back 0x55 then 0x2A, no idle gap.
    expect_word(7'h55, 1'b0);
    expect_word(7'h2A, 1'b0);
    send_frame(7'h55, 1'b1, 1'b0);
    send_frame(7'h2A, 1'b1, 1'b0);
    idle(DIV);
    chk("b2b_drained", exp_q.size(), 0);
    chk("b2b_last", 32'(data_received), 32'h2A);

    // Start-bit glitch shorter than half a bit.
    idle(DIV);
    rx_line = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx_line = 1'b1;
    @(negedge clk);
    chk("glitch_busy", 32'(busy), 1);
    repeat (HALF + 4) @(posedge clk);
    @(negedge clk);
    chk("glitch_idle", 32'(busy), 0);
    chk("glitch_nopulse", exp_q.size(), 0);
    #1;

    // Stop bit forced low: framing error, word retained.
    expect_ferr();
    send_frame(7'h7F, 1'b0, 1'b0);
    idle(DIV);
    chk("ferr_drained", exp_q.size(), 0);
    chk("ferr_keep", 32'(data_received), 32'h2A);

    // Break: held low well past a frame gives a single framing error.
    expect_ferr();
    send_frame(7'h00, 1'b0, 1'b0);
    rx_line = 1'b0;
    repeat (30 * DIV) @(posedge clk);
    #1;
    idle(2 * DIV);
    chk("break_drained", exp_q.size(), 0);
    chk("break_idle", 32'(busy), 0);

    // Reset during data bit 3 of 0x13 discards the partial word.
    w = 7'h13;
    bit_out(1'b0);
    for (int i = 0; i < 3; i++) bit_out(w[i]);
    rx_line = w[3];
    repeat (HALF) @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx_line = 1'b1;
    reset = 1'b1;
    idle(2 * DIV);
    chk("rst_nopulse", exp_q.size(), 0);
    expect_word(7'h13, 1'b0);
    send_frame(7'h13, 1'b1, 1'b0);
    idle(DIV);
    chk("rst_drained", exp_q.size(), 0);
    chk("rst_word", 32'(data_received), 32'h13);

`ifdef UART_RX_PARITY_EN
    // Wrong parity still delivers the word.
    expect_word(7'h03, 1'b1);
    send_frame(7'h03, 1'b1, 1'b1);
    idle(DIV);
    chk("par_drained", exp_q.size(), 0);
`endif

    // Random words with random idle gaps (gap 0 exercises back-to-back).
    for (int n = 0; n < 100; n++) begin
      w = DW'($urandom);
      expect_word(w, 1'b0);
      send_frame(w, 1'b1, 1'b0);
      if ($urandom_range(0, 3) != 0) idle($urandom_range(1, 20));
    end
    idle(2 * DIV);
    chk("rand_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
